// File: rtl/phy_pkg.sv
// Shared PHY definitions: K-code values used by the tx symbol mux and the rx deframer,
// the rx deframer state enum, packet type constants and the rx output payload bundle.
package phy_pkg;

    localparam int unsigned SYM_W = 8;

    // Control characters (valid only with the K flag set)
    localparam logic [SYM_W-1:0] K_STP = 8'hFB;
    localparam logic [SYM_W-1:0] K_SDP = 8'h5C;
    localparam logic [SYM_W-1:0] K_END = 8'hFD;
    localparam logic [SYM_W-1:0] K_EDB = 8'hFE;
    localparam logic [SYM_W-1:0] K_SKP = 8'h1C;
    localparam logic [SYM_W-1:0] K_IDL = 8'h7C;
    localparam logic [SYM_W-1:0] K_FTS = 8'h3C;
    localparam logic [SYM_W-1:0] K_COM = 8'hBC;

    localparam logic TYPE_TLP  = 1'b0;
    localparam logic TYPE_DLLP = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PKT     = 2'd1,
        DISCARD = 2'd2
    } rx_state_t;

    // One output beat towards the link layer
    typedef struct packed {
        logic [SYM_W-1:0] data;
        logic             valid;
        logic             sop;
        logic             eop;
        logic             err;
    } rx_out_t;

endpackage

// File: rtl/phy_rx_sym_classify.sv
// Combinational decode of one received symbol {k_in, data_in} into framing classes.
// Ports:
//   data_in, k_in   symbol byte and its control flag
//   is_data_c       plain data byte
//   is_start_c      STP or SDP; start_dllp_c marks SDP
//   is_end_c        END
//   is_edb_c        EDB (nullified end)
//   is_other_k_c    any other control character (SKP/IDL/FTS/COM/unknown)
module phy_rx_sym_classify
    import phy_pkg::*;
(
    input  logic [SYM_W-1:0] data_in,
    input  logic             k_in,
    output logic             is_data_c,
    output logic             is_start_c,
    output logic             start_dllp_c,
    output logic             is_end_c,
    output logic             is_edb_c,
    output logic             is_other_k_c
);

    always_comb begin
        is_data_c    = 1'b0;
        is_start_c   = 1'b0;
        start_dllp_c = 1'b0;
        is_end_c     = 1'b0;
        is_edb_c     = 1'b0;
        is_other_k_c = 1'b0;
        if (!k_in) begin
            is_data_c = 1'b1;
        end else begin
            case (data_in)
                K_STP:   is_start_c = 1'b1;
                K_SDP: begin
                    is_start_c   = 1'b1;
                    start_dllp_c = 1'b1;
                end
                K_END:   is_end_c = 1'b1;
                K_EDB:   is_edb_c = 1'b1;
                default: is_other_k_c = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/phy_rx_deframer.sv
// Receive-side deframer: strips STP/SDP ... END/EDB framing from the PHY symbol stream
// and emits payload bytes with SOP/EOP/ERR markers. Ordered sets and COM are dropped.
// Each payload byte is held until the next valid symbol decides whether it is the last.
// Optional build macro: PHY_RX_STATS_EN adds the good_cnt/bad_cnt packet counters.
// Ports:
//   clk, reset_l          clock, async active-low reset
//   data_in, k_in         symbol byte and control flag, qualified by valid_in
//   data_out, valid_out   payload byte and its one-cycle strobe
//   sop_out, eop_out      first / last payload byte markers
//   err_out               with eop_out: bad packet; alone: zero-length framing error
//   type_out              0 = TLP, 1 = DLLP for the current packet
//   good_cnt, bad_cnt     packet statistics (PHY_RX_STATS_EN only)
module phy_rx_deframer
    import phy_pkg::*;
#(
    parameter int unsigned MAX_LEN = 64
`ifdef PHY_RX_STATS_EN
    , parameter int unsigned CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic [SYM_W-1:0] data_in,
    input  logic             k_in,
    input  logic             valid_in,
    output logic [SYM_W-1:0] data_out,
    output logic             valid_out,
    output logic             sop_out,
    output logic             eop_out,
    output logic             err_out,
    output logic             type_out
`ifdef PHY_RX_STATS_EN
    , output logic [CNT_W-1:0] good_cnt
    , output logic [CNT_W-1:0] bad_cnt
`endif
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    logic is_data_c, is_start_c, start_dllp_c, is_end_c, is_edb_c, is_other_k_c;

    rx_state_t        state_q, state_d;
    logic [SYM_W-1:0] hold_q, hold_d;
    logic             hold_sop_q, hold_sop_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             type_q, type_d;
    rx_out_t          out_q, out_d;

    // Per-symbol emit decision, folded into out_d after the FSM case
    logic emit_c, last_c, bad_c;

    phy_rx_sym_classify u_classify (
        .data_in      (data_in),
        .k_in         (k_in),
        .is_data_c    (is_data_c),
        .is_start_c   (is_start_c),
        .start_dllp_c (start_dllp_c),
        .is_end_c     (is_end_c),
        .is_edb_c     (is_edb_c),
        .is_other_k_c (is_other_k_c)
    );

    // Next-state, hold register and output beat
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_sop_d = hold_sop_q;
        len_d      = len_q;
        type_d     = type_q;
        emit_c     = 1'b0;
        last_c     = 1'b0;
        bad_c      = 1'b0;

        if (valid_in) begin
            case (state_q)
                IDLE: begin
                    if (is_start_c) begin
                        state_d = PKT;
                        type_d  = start_dllp_c;
                        len_d   = '0;
                    end
                end
                PKT: begin
                    if (is_data_c) begin
                        if (len_q < LEN_W'(MAX_LEN)) begin
                            // Previous held byte is now known not to be the last
                            emit_c     = (len_q != '0);
                            hold_d     = data_in;
                            hold_sop_d = (len_q == '0);
                            len_d      = len_q + LEN_W'(1);
                        end else begin
                            emit_c  = 1'b1;
                            last_c  = 1'b1;
                            bad_c   = 1'b1;
                            state_d = DISCARD;
                        end
                    end else if (is_end_c || is_edb_c) begin
                        emit_c  = (len_q != '0);
                        last_c  = (len_q != '0);
                        bad_c   = is_edb_c || (len_q == '0);
                        state_d = IDLE;
                    end else if (is_start_c) begin
                        // Missing end: close the old packet as bad, open the new one
                        emit_c  = (len_q != '0);
                        last_c  = (len_q != '0);
                        bad_c   = 1'b1;
                        type_d  = start_dllp_c;
                        len_d   = '0;
                    end else if (is_other_k_c) begin
                        emit_c  = (len_q != '0);
                        last_c  = (len_q != '0);
                        bad_c   = 1'b1;
                        state_d = IDLE;
                    end
                end
                DISCARD: begin
                    if (is_end_c || is_edb_c) begin
                        state_d = IDLE;
                    end else if (is_start_c) begin
                        state_d = PKT;
                        type_d  = start_dllp_c;
                        len_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        out_d       = '0;
        out_d.data  = emit_c ? hold_q : out_q.data;
        out_d.valid = emit_c;
        out_d.sop   = emit_c & hold_sop_q;
        out_d.eop   = last_c;
        out_d.err   = bad_c;
    end

    // State, hold and output registers
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            hold_sop_q <= 1'b0;
            len_q      <= '0;
            type_q     <= TYPE_TLP;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_sop_q <= hold_sop_d;
            len_q      <= len_d;
            type_q     <= type_d;
            out_q      <= out_d;
        end
    end

    assign data_out  = out_q.data;
    assign valid_out = out_q.valid;
    assign sop_out   = out_q.sop;
    assign eop_out   = out_q.eop;
    assign err_out   = out_q.err;
    assign type_out  = type_q;

`ifdef PHY_RX_STATS_EN
    // Packet statistics, counted on the same edge that launches EOP / lone ERR
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            good_cnt <= good_cnt + CNT_W'(out_d.eop & ~out_d.err);
            bad_cnt  <= bad_cnt + CNT_W'(out_d.err);
        end
    end
`endif

endmodule

// File: tb/tb_phy_rx_deframer.sv
// Scoreboard bench for phy_rx_deframer (built with MAX_LEN = 4).
module tb_phy_rx_deframer;

    logic       clk;
    logic       reset_l;
    logic [7:0] data_in;
    logic       k_in;
    logic       valid_in;
    logic [7:0] data_out;
    logic       valid_out, sop_out, eop_out, err_out, type_out;
`ifdef PHY_RX_STATS_EN
    logic [15:0] good_cnt, bad_cnt;
`endif

    phy_rx_deframer #(.MAX_LEN(4)) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .data_in   (data_in),
        .k_in      (k_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .sop_out   (sop_out),
        .eop_out   (eop_out),
        .err_out   (err_out),
        .type_out  (type_out)
`ifdef PHY_RX_STATS_EN
        , .good_cnt (good_cnt)
        , .bad_cnt  (bad_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       sop;
        logic       eop;
        logic       err;
        logic       typ;
        logic       chk_type;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_good = 0;
    int   exp_bad  = 0;
    int   entry_no = 0;

    task automatic exp_byte(input logic [7:0] d, input logic sop, input logic eop,
                            input logic err, input logic typ, input logic chk);
        exp_t e;
        e.data = d; e.valid = 1'b1; e.sop = sop; e.eop = eop; e.err = err;
        e.typ = typ; e.chk_type = chk;
        sbq.push_back(e);
    endtask

    task automatic exp_lone_err();
        exp_t e;
        e.data = 8'h00; e.valid = 1'b0; e.sop = 1'b0; e.eop = 1'b0; e.err = 1'b1;
        e.typ = 1'b0; e.chk_type = 1'b0;
        sbq.push_back(e);
    endtask

    task automatic sym(input logic k, input logic [7:0] d);
        @(negedge clk);
        valid_in = 1'b1;
        k_in     = k;
        data_in  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_in = 1'b0;
        end
    endtask

    // Output monitor: every output event must match the head of the scoreboard
    exp_t mon_e;
    bit   mon_mis;
    always @(negedge clk) begin
        if (valid_out | sop_out | eop_out | err_out) begin
            total++;
            entry_no++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: got valid=%0b data=%02h sop=%0b eop=%0b err=%0b, want no output",
                         valid_out, data_out, sop_out, eop_out, err_out);
            end else begin
                mon_e   = sbq.pop_front();
                mon_mis = (valid_out !== mon_e.valid) || (sop_out !== mon_e.sop) ||
                          (eop_out !== mon_e.eop) || (err_out !== mon_e.err) ||
                          (mon_e.valid && (data_out !== mon_e.data)) ||
                          (mon_e.chk_type && (type_out !== mon_e.typ));
                if (mon_mis) begin
                    bad++;
                    $display("FAIL sb_out[%0d]: got valid=%0b data=%02h sop=%0b eop=%0b err=%0b type=%0b, want valid=%0b data=%02h sop=%0b eop=%0b err=%0b type=%0b",
                             entry_no, valid_out, data_out, sop_out, eop_out, err_out, type_out,
                             mon_e.valid, mon_e.data, mon_e.sop, mon_e.eop, mon_e.err, mon_e.typ);
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d outputs still missing, want 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_stats(input string name);
`ifdef PHY_RX_STATS_EN
        total++;
        if (good_cnt !== 16'(exp_good)) begin
            bad++;
            $display("FAIL %s_good_cnt: got %0d want %0d", name, good_cnt, exp_good);
        end
        total++;
        if (bad_cnt !== 16'(exp_bad)) begin
            bad++;
            $display("FAIL %s_bad_cnt: got %0d want %0d", name, bad_cnt, exp_bad);
        end
`else
        if (name.len() == 0) $display("stats disabled");
`endif
    endtask

    task automatic test_reset();
        reset_l  = 1'b0;
        valid_in = 1'b0;
        k_in     = 1'b0;
        data_in  = 8'h00;
        repeat (3) @(negedge clk);
        total++;
        if ({valid_out, sop_out, eop_out, err_out, type_out} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %05b want 00000",
                     {valid_out, sop_out, eop_out, err_out, type_out});
        end
        total++;
        if (data_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_data: got %02h want 00", data_out);
        end
        reset_l = 1'b1;
        exp_good = 0;
        exp_bad  = 0;
        idle(2);
        test_stats("reset");
    endtask

    task automatic test_good_tlp();
        exp_byte(8'h01, 1, 0, 0, 0, 1);
        exp_byte(8'h02, 0, 0, 0, 0, 1);
        exp_byte(8'h03, 0, 1, 0, 0, 1);
        exp_good++;
        sym(1, 8'hFB); sym(0, 8'h01); sym(0, 8'h02); sym(0, 8'h03); sym(1, 8'hFD);
        idle(1);
        wait_drain("good_tlp");
        total++;
        if (data_out !== 8'h03) begin
            bad++;
            $display("FAIL good_tlp_data_hold: got %02h want 03", data_out);
        end
        test_stats("good_tlp");
    endtask

    task automatic test_nullified_dllp();
        exp_byte(8'hAA, 1, 0, 0, 1, 1);
        exp_byte(8'hBB, 0, 1, 1, 1, 1);
        exp_bad++;
        sym(1, 8'h5C); sym(0, 8'hAA); sym(0, 8'hBB); sym(1, 8'hFE);
        idle(1);
        wait_drain("null_dllp");
        test_stats("null_dllp");
    endtask

    task automatic test_oversize();
        exp_byte(8'h10, 1, 0, 0, 0, 1);
        exp_byte(8'h11, 0, 0, 0, 0, 1);
        exp_byte(8'h12, 0, 0, 0, 0, 1);
        exp_byte(8'h13, 0, 1, 1, 0, 1);
        exp_bad++;
        sym(1, 8'hFB);
        for (int i = 0; i < 6; i++) sym(0, 8'(8'h10 + i));
        sym(1, 8'hFD);
        // Back in IDLE: stray data and END must be ignored
        sym(0, 8'h77); sym(1, 8'hFD);
        idle(1);
        wait_drain("oversize");
        test_stats("oversize");
    endtask

    task automatic test_exact_max();
        exp_byte(8'h21, 1, 0, 0, 1, 1);
        exp_byte(8'h22, 0, 0, 0, 1, 1);
        exp_byte(8'h23, 0, 0, 0, 1, 1);
        exp_byte(8'h24, 0, 1, 0, 1, 1);
        exp_good++;
        sym(1, 8'h5C);
        for (int i = 1; i <= 4; i++) sym(0, 8'(8'h20 + i));
        sym(1, 8'hFD);
        idle(1);
        wait_drain("exact_max");
        test_stats("exact_max");
    endtask

    task automatic test_framing();
        exp_lone_err();
        exp_bad++;
        sym(1, 8'hFB); sym(1, 8'hFD);
        idle(1);
        wait_drain("zero_len");
        total++;
        if (type_out !== 1'b0) begin
            bad++;
            $display("FAIL zero_len_type: got %0b want 0", type_out);
        end
        exp_byte(8'h11, 1, 1, 1, 0, 0);
        exp_byte(8'h22, 1, 1, 0, 1, 1);
        exp_bad++;
        exp_good++;
        sym(1, 8'hFB); sym(0, 8'h11); sym(1, 8'h5C); sym(0, 8'h22); sym(1, 8'hFD);
        idle(1);
        wait_drain("missing_end");
        test_stats("framing");
    endtask

    task automatic test_idle_noise();
        sym(1, 8'h7C); sym(1, 8'h1C); sym(1, 8'hBC); sym(0, 8'h55); sym(1, 8'h3C);
        idle(1);
        wait_drain("idle_noise");
    endtask

    task automatic test_gaps();
        exp_byte(8'h31, 1, 0, 0, 0, 1);
        exp_byte(8'h32, 0, 0, 0, 0, 1);
        exp_byte(8'h33, 0, 1, 0, 0, 1);
        exp_good++;
        sym(1, 8'hFB); idle($urandom_range(1, 3));
        sym(0, 8'h31); idle($urandom_range(1, 3));
        sym(0, 8'h32); idle($urandom_range(1, 3));
        sym(0, 8'h33); idle($urandom_range(1, 3));
        sym(1, 8'hFD);
        idle(1);
        wait_drain("gaps");
        test_stats("gaps");
    endtask

    task automatic test_back_to_back();
        exp_byte(8'h41, 1, 1, 0, 1, 1);
        exp_byte(8'h42, 1, 0, 0, 0, 1);
        exp_byte(8'h43, 0, 1, 0, 0, 1);
        exp_good += 2;
        sym(1, 8'h5C); sym(0, 8'h41); sym(1, 8'hFD);
        sym(1, 8'hFB); sym(0, 8'h42); sym(0, 8'h43); sym(1, 8'hFD);
        idle(1);
        wait_drain("b2b");
        test_stats("b2b");
    endtask

    task automatic test_reset_mid();
        exp_byte(8'h01, 1, 0, 0, 0, 1);
        sym(1, 8'hFB); sym(0, 8'h01); sym(0, 8'h02);
        @(negedge clk);
        valid_in = 1'b0;
        #2 reset_l = 1'b0;
        #1;
        total++;
        if ({valid_out, sop_out, eop_out, err_out, type_out} !== 5'b0 || data_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_outputs: got flags=%05b data=%02h want flags=00000 data=00",
                     {valid_out, sop_out, eop_out, err_out, type_out}, data_out);
        end
        exp_good = 0;
        exp_bad  = 0;
        @(negedge clk);
        reset_l = 1'b1;
        sym(0, 8'h03); sym(1, 8'hFD);
        idle(1);
        wait_drain("reset_tail");
        test_stats("reset_mid");
        exp_byte(8'h0A, 1, 0, 0, 0, 1);
        exp_byte(8'h0B, 0, 1, 0, 0, 1);
        exp_good++;
        sym(1, 8'hFB); sym(0, 8'h0A); sym(0, 8'h0B); sym(1, 8'hFD);
        idle(1);
        wait_drain("after_reset");
        test_stats("after_reset");
    endtask

    initial begin
        test_reset();
        test_good_tlp();
        test_nullified_dllp();
        test_oversize();
        test_exact_max();
        test_framing();
        test_idle_noise();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
